sgmii_rx_pcs: RTL and testbench

Receive-side 1000BASE-X/SGMII PCS stage that consumes decoded 8b/10b characters from the SGMII bridge's decoder at 312.5 MHz. It runs the receive ordered-set state machine and parses /C/ configuration ordered sets into a link-up/speed result. It converts /S/…/T/ framed data into a clock-enabled GMII-style byte stream. Rate-adaptation de-replication (10/100M) is performed downstream; this block outputs one beat per received character.

---
 rtl/sgmii_rx_pcs.sv | 225 ++++++++++++++++++++++
 tb/tb_sgmii_rx_pcs.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgmii_rx_pcs.sv
// SGMII/1000BASE-X receive PCS: ordered-set FSM, /C/ config parsing, link control and GMII beat output.
// Define SGMII_RX_PCS_STATS_EN to add the saturating rx_err_count / rx_frame_count outputs.
module sgmii_rx_pcs #(
  parameter int LINK_TIMEOUT = 4096
) (
  input  logic        clk_312p5mhz,
  input  logic        rst_n,
  input  logic        rx_data_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_is_ctl,
  input  logic        rx_symbol_err,
  input  logic        rx_disparity_err,
  input  logic        rx_locked,
  output logic        gmii_rx_valid,
  output logic        gmii_rx_en,
  output logic        gmii_rx_er,
  output logic [7:0]  gmii_rxd,
  output logic        rx_cfg_valid,
  output logic [15:0] rx_cfg_word,
  output logic        link_up,
  output logic [1:0]  link_speed
`ifdef SGMII_RX_PCS_STATS_EN
  ,
  output logic [15:0] rx_err_count,
  output logic [15:0] rx_frame_count
`endif
);

  localparam logic [7:0]  K28_5         = 8'hBC;
  localparam logic [7:0]  K27_7         = 8'hFB;
  localparam logic [7:0]  K29_7         = 8'hFD;
  localparam logic [7:0]  D21_5         = 8'hB5;
  localparam logic [7:0]  D2_2          = 8'h42;
  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [15:0] ACK_MASK      = 16'hBFFF;
  localparam logic [12:0] TIMEOUT_LIMIT = 13'(LINK_TIMEOUT);

  typedef enum logic [2:0] {
    WAIT_COMMA,
    COMMA,
    CFG_LO,
    CFG_HI,
    DATA
  } state_t;

  state_t      state, state_next;
  logic        beat_valid, beat_en, beat_er;
  logic [7:0]  beat_rxd;
  logic        cfg_pulse;
  logic [15:0] cfg_word_next;
  logic [7:0]  cfg_lo, cfg_lo_next;
  logic [15:0] prev_word, prev_word_next;
  logic [1:0]  match_cnt, match_next;
  logic        link_up_next;
  logic [1:0]  speed_next;
  logic [12:0] timer, timer_next;
  logic        char_err, is_comma;
  logic [15:0] new_word;
`ifdef SGMII_RX_PCS_STATS_EN
  logic        frame_done;
`endif

  assign char_err = rx_symbol_err | rx_disparity_err;
  assign is_comma = rx_data_is_ctl && (rx_data == K28_5);
  assign new_word = {rx_data, cfg_lo};

  always_comb begin
    state_next     = state;
    beat_valid     = 1'b0;
    beat_en        = 1'b0;
    beat_er        = 1'b0;
    beat_rxd       = 8'h00;
    cfg_pulse      = 1'b0;
    cfg_word_next  = rx_cfg_word;
    cfg_lo_next    = cfg_lo;
    prev_word_next = prev_word;
    match_next     = match_cnt;
    link_up_next   = link_up;
    speed_next     = link_speed;
    timer_next     = timer;
`ifdef SGMII_RX_PCS_STATS_EN
    frame_done     = 1'b0;
`endif
    if (!rx_locked) begin
      // Lock loss abandons everything; an open frame is terminated with one error beat.
      state_next   = WAIT_COMMA;
      link_up_next = 1'b0;
      match_next   = 2'd0;
      timer_next   = 13'd0;
      if (state == DATA) begin
        beat_valid = 1'b1;
        beat_en    = 1'b1;
        beat_er    = 1'b1;
      end
    end else if (rx_data_valid) begin
      beat_valid = 1'b1;
      case (state)
        WAIT_COMMA: begin
          if (is_comma) begin
            state_next = COMMA;
          end else if (rx_data_is_ctl && (rx_data == K27_7)) begin
            state_next = DATA;
            beat_en    = 1'b1;
            beat_rxd   = PREAMBLE;
          end
        end
        COMMA: begin
          if (!rx_data_is_ctl && ((rx_data == D21_5) || (rx_data == D2_2)))
            state_next = CFG_LO;
          else
            state_next = WAIT_COMMA;
        end
        CFG_LO: begin
          if (rx_data_is_ctl || char_err) begin
            match_next = 2'd0;
            state_next = WAIT_COMMA;
          end else begin
            cfg_lo_next = rx_data;
            state_next  = CFG_HI;
          end
        end
        CFG_HI: begin
          state_next = WAIT_COMMA;
          if (rx_data_is_ctl || char_err) begin
            match_next = 2'd0;
          end else begin
            cfg_pulse      = 1'b1;
            cfg_word_next  = new_word;
            prev_word_next = new_word;
            // The ack bit toggles during autonegotiation, so it must not break the match run.
            if ((new_word & ACK_MASK) == (prev_word & ACK_MASK))
              match_next = (match_cnt == 2'd3) ? 2'd3 : match_cnt + 2'd1;
            else
              match_next = 2'd1;
            if (match_next == 2'd3) begin
              if (!new_word[15]) begin
                link_up_next = 1'b0;
              end else if (new_word[0]) begin
                link_up_next = 1'b1;
                speed_next   = (new_word[11:10] == 2'b11) ? 2'b00 : new_word[11:10];
              end
            end
          end
        end
        DATA: begin
          beat_en  = 1'b1;
          beat_rxd = rx_data;
          if (char_err) begin
            beat_er = 1'b1;
          end else if (rx_data_is_ctl) begin
            if (rx_data == K29_7) begin
              beat_en    = 1'b0;
              beat_rxd   = 8'h00;
              state_next = WAIT_COMMA;
`ifdef SGMII_RX_PCS_STATS_EN
              frame_done = 1'b1;
`endif
            end else begin
              beat_er = 1'b1;
              if (rx_data == K28_5)
                state_next = COMMA;
            end
          end
        end
        default: state_next = WAIT_COMMA;
      endcase
      // Link watchdog counts characters since the last comma and overrides the FSM result.
      if (is_comma)
        timer_next = 13'd0;
      else if (timer != 13'h1FFF)
        timer_next = timer + 13'd1;
      if (timer_next >= TIMEOUT_LIMIT) begin
        link_up_next = 1'b0;
        match_next   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk_312p5mhz) begin
    if (!rst_n) begin
      state         <= WAIT_COMMA;
      cfg_lo        <= 8'h00;
      prev_word     <= 16'h0000;
      match_cnt     <= 2'd0;
      timer         <= 13'd0;
      gmii_rx_valid <= 1'b0;
      gmii_rx_en    <= 1'b0;
      gmii_rx_er    <= 1'b0;
      gmii_rxd      <= 8'h00;
      rx_cfg_valid  <= 1'b0;
      rx_cfg_word   <= 16'h0000;
      link_up       <= 1'b0;
      link_speed    <= 2'b00;
    end else begin
      state         <= state_next;
      cfg_lo        <= cfg_lo_next;
      prev_word     <= prev_word_next;
      match_cnt     <= match_next;
      timer         <= timer_next;
      gmii_rx_valid <= beat_valid;
      gmii_rx_en    <= beat_en;
      gmii_rx_er    <= beat_er;
      gmii_rxd      <= beat_rxd;
      rx_cfg_valid  <= cfg_pulse;
      rx_cfg_word   <= cfg_word_next;
      link_up       <= link_up_next;
      link_speed    <= speed_next;
    end
  end

`ifdef SGMII_RX_PCS_STATS_EN
  always_ff @(posedge clk_312p5mhz) begin
    if (!rst_n) begin
      rx_err_count   <= 16'h0000;
      rx_frame_count <= 16'h0000;
    end else begin
      if (beat_valid && beat_er && (rx_err_count != 16'hFFFF))
        rx_err_count <= rx_err_count + 16'd1;
      if (frame_done && (rx_frame_count != 16'hFFFF))
        rx_frame_count <= rx_frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sgmii_rx_pcs.sv
// Self-checking bench for sgmii_rx_pcs: directed test-plan steps plus randomized ordered-set traffic
// checked against a character/token-level reference model.
module tb_sgmii_rx_pcs;

  localparam int LINK_TIMEOUT = 4096;

  logic        clk_312p5mhz = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_is_ctl = 1'b0;
  logic        rx_symbol_err = 1'b0;
  logic        rx_disparity_err = 1'b0;
  logic        rx_locked = 1'b1;
  logic        gmii_rx_valid, gmii_rx_en, gmii_rx_er;
  logic [7:0]  gmii_rxd;
  logic        rx_cfg_valid;
  logic [15:0] rx_cfg_word;
  logic        link_up;
  logic [1:0]  link_speed;
`ifdef SGMII_RX_PCS_STATS_EN
  logic [15:0] rx_err_count, rx_frame_count;
`endif

  sgmii_rx_pcs #(.LINK_TIMEOUT(LINK_TIMEOUT)) dut (
    .clk_312p5mhz     (clk_312p5mhz),
    .rst_n            (rst_n),
    .rx_data_valid    (rx_data_valid),
    .rx_data          (rx_data),
    .rx_data_is_ctl   (rx_data_is_ctl),
    .rx_symbol_err    (rx_symbol_err),
    .rx_disparity_err (rx_disparity_err),
    .rx_locked        (rx_locked),
    .gmii_rx_valid    (gmii_rx_valid),
    .gmii_rx_en       (gmii_rx_en),
    .gmii_rx_er       (gmii_rx_er),
    .gmii_rxd         (gmii_rxd),
    .rx_cfg_valid     (rx_cfg_valid),
    .rx_cfg_word      (rx_cfg_word),
    .link_up          (link_up),
`ifdef SGMII_RX_PCS_STATS_EN
    .rx_err_count     (rx_err_count),
    .rx_frame_count   (rx_frame_count),
`endif
    .link_speed       (link_speed)
  );

  always #2 clk_312p5mhz = ~clk_312p5mhz;

  int checks = 0;
  int failures = 0;
  string ctx = "reset";

  // Reference model: link/config state kept at ordered-set level.
  int          m_count;
  logic [15:0] m_last;
  logic        m_up;
  logic [1:0]  m_speed;
  logic [15:0] m_cfg_word;
  int          m_since;
  int          m_err_beats;
  int          m_frames;
  logic [7:0]  frame_q[$];

  task automatic modelReset();
    m_count = 0; m_last = 16'h0000; m_up = 1'b0; m_speed = 2'b00;
    m_cfg_word = 16'h0000; m_since = 0; m_err_beats = 0; m_frames = 0;
  endtask

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic exp_valid, input logic exp_en, input logic exp_er,
                             input logic chk_rxd, input logic [7:0] exp_rxd, input logic exp_cfgv);
    checkVal({ctx, " gmii_rx_valid"}, 16'(gmii_rx_valid), 16'(exp_valid));
    checkVal({ctx, " gmii_rx_en"}, 16'(gmii_rx_en), 16'(exp_en));
    checkVal({ctx, " gmii_rx_er"}, 16'(gmii_rx_er), 16'(exp_er));
    if (chk_rxd) checkVal({ctx, " gmii_rxd"}, 16'(gmii_rxd), 16'(exp_rxd));
    checkVal({ctx, " rx_cfg_valid"}, 16'(rx_cfg_valid), 16'(exp_cfgv));
    checkVal({ctx, " rx_cfg_word"}, rx_cfg_word, m_cfg_word);
    checkVal({ctx, " link_up"}, 16'(link_up), 16'(m_up));
    checkVal({ctx, " link_speed"}, 16'(link_speed), 16'(m_speed));
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic ctl, input logic sym, input logic disp);
    rx_data_valid = 1'b1; rx_data = d; rx_data_is_ctl = ctl;
    rx_symbol_err = sym; rx_disparity_err = disp;
    @(posedge clk_312p5mhz);
    #1;
  endtask

  task automatic modelConfig(input logic [15:0] w);
    if (m_count > 0 && ((w & 16'hBFFF) == (m_last & 16'hBFFF)))
      m_count = (m_count >= 3) ? 3 : m_count + 1;
    else
      m_count = 1;
    m_last = w;
    m_cfg_word = w;
    if (m_count == 3) begin
      if (!w[15]) m_up = 1'b0;
      else if (w[0]) begin
        m_up = 1'b1;
        m_speed = (w[11:10] == 2'b11) ? 2'b00 : w[11:10];
      end
    end
  endtask

  task automatic sendChar(input logic [7:0] d, input logic ctl, input logic sym, input logic disp,
                          input logic exp_en, input logic exp_er, input logic chk_rxd,
                          input logic [7:0] exp_rxd, input logic cfg_pulse,
                          input logic [15:0] word, input logic clear_count);
    applyStimulus(d, ctl, sym, disp);
    if (clear_count) m_count = 0;
    if (cfg_pulse) modelConfig(word);
    m_since = (ctl && d == 8'hBC) ? 0 : m_since + 1;
    if (m_since >= LINK_TIMEOUT) begin
      m_up = 1'b0;
      m_count = 0;
    end
    if (exp_er) m_err_beats++;
    checkOutput(1'b1, exp_en, exp_er, chk_rxd, exp_rxd, cfg_pulse);
  endtask

  task automatic plainChar(input logic [7:0] d, input logic ctl);
    sendChar(d, ctl, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b0);
  endtask

  // err_where: 0 none, 1 low byte, 2 high byte; err_kind: 0 K char, 1 symbol, 2 disparity.
  task automatic sendConfig(input logic [15:0] w, input int err_where, input int err_kind);
    plainChar(8'hBC, 1'b1);
    plainChar(($urandom_range(0, 1) == 1) ? 8'hB5 : 8'h42, 1'b0);
    if (err_where == 1) begin
      sendChar(w[7:0], err_kind == 0, err_kind == 1, err_kind == 2,
               1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1);
      plainChar(w[15:8], 1'b0);
    end else begin
      plainChar(w[7:0], 1'b0);
      if (err_where == 2)
        sendChar(w[15:8], err_kind == 0, err_kind == 1, err_kind == 2,
                 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1);
      else
        sendChar(w[15:8], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, w, 1'b0);
    end
  endtask

  task automatic sendIdle();
    plainChar(8'hBC, 1'b1);
    plainChar(($urandom_range(0, 1) == 1) ? 8'hC5 : 8'h50, 1'b0);
  endtask

  task automatic sendFrameStart();
    sendChar(8'hFB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic sendDataByte(input logic [7:0] b, input int err_kind);
    sendChar(b, 1'b0, err_kind == 1, err_kind == 2, 1'b1, err_kind != 0, 1'b1, b,
             1'b0, 16'h0000, 1'b0);
  endtask

  // Full frame from frame_q: /S/, payload, /T/, /R/; err_kind 1 symbol, 2 disparity at err_idx.
  task automatic sendFrame(input int err_idx, input int err_kind);
    sendFrameStart();
    foreach (frame_q[i]) sendDataByte(frame_q[i], (i == err_idx) ? err_kind : 0);
    plainChar(8'hFD, 1'b1);
    m_frames++;
    plainChar(8'hF7, 1'b1);
  endtask

  task automatic idleCycle();
    rx_data_valid = 1'b0; rx_symbol_err = 1'b0; rx_disparity_err = 1'b0;
    @(posedge clk_312p5mhz);
    #1;
    checkOutput(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] w;
    int reps, len, eidx, ekind, ew;
    modelReset();

    ctx = "reset";
    repeat (3) @(posedge clk_312p5mhz);
    #1;
    checkOutput(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    rst_n = 1'b1;
    idleCycle();

    ctx = "bringup";
    repeat (3) sendConfig(16'hD801, 0, 0);
    checkVal("bringup link_up", 16'(link_up), 16'h1);
    checkVal("bringup link_speed", 16'(link_speed), 16'h2);

    ctx = "ack";
    repeat (3) sendConfig(16'h0001, 0, 0);
    checkVal("ack drop link_up", 16'(link_up), 16'h0);
    sendConfig(16'hD801, 0, 0);
    sendConfig(16'h9801, 0, 0);
    sendConfig(16'hD801, 0, 0);
    checkVal("ack tolerant link_up", 16'(link_up), 16'h1);
    repeat (3) sendConfig(16'h0001, 0, 0);
    checkVal("ack final link_up", 16'(link_up), 16'h0);

    ctx = "frame";
    sendIdle();
    frame_q = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    sendFrame(-1, 0);
    sendIdle();

    ctx = "frame_err";
    sendFrame(1, 1);
    sendIdle();

    ctx = "midcomma";
    sendFrameStart();
    sendDataByte(8'h12, 0);
    sendChar(8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    plainChar(8'hC5, 1'b0);
    frame_q = {8'hA1, 8'hB2, 8'hC3};
    sendFrame(-1, 0);
    idleCycle();

    ctx = "random";
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 2))
        0: sendIdle();
        1: begin
          len = $urandom_range(1, 16);
          frame_q = {};
          for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
          eidx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
          sendFrame(eidx, $urandom_range(1, 2));
        end
        default: begin
          case ($urandom_range(0, 6))
            0: w = 16'hD801;
            1: w = 16'h9401;
            2: w = 16'hD001;
            3: w = 16'hDC01;
            4: w = 16'h0001;
            5: w = 16'hD800;
            default: w = 16'($urandom);
          endcase
          reps = $urandom_range(1, 4);
          for (int r = 0; r < reps; r++) begin
            ew = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
            ekind = $urandom_range(0, 2);
            sendConfig(($urandom_range(0, 1) == 1) ? (w ^ 16'h4000) : w, ew, ekind);
          end
        end
      endcase
    end
    idleCycle();

    ctx = "lockloss";
    repeat (3) sendConfig(16'hD401, 0, 0);
    checkVal("lockloss pre link_speed", 16'(link_speed), 16'h1);
    sendFrameStart();
    sendDataByte(8'hA5, 0);
    rx_locked = 1'b0; rx_data_valid = 1'b0;
    @(posedge clk_312p5mhz);
    #1;
    m_up = 1'b0; m_count = 0; m_since = 0; m_err_beats++;
    checkOutput(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
    @(posedge clk_312p5mhz);
    #1;
    checkOutput(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rx_locked = 1'b1;
    sendIdle();

    ctx = "timeout";
    repeat (3) sendConfig(16'hD801, 0, 0);
    checkVal("timeout pre link_up", 16'(link_up), 16'h1);
    for (int i = 0; i < LINK_TIMEOUT; i++) plainChar(8'h00, 1'b0);
    checkVal("timeout link_up", 16'(link_up), 16'h0);

    ctx = "midreset";
    sendIdle();
    repeat (3) sendConfig(16'hD801, 0, 0);
    sendFrameStart();
    sendDataByte(8'h11, 0);
    rst_n = 1'b0;
    rx_data_valid = 1'b1; rx_data = 8'h22; rx_data_is_ctl = 1'b0;
    @(posedge clk_312p5mhz);
    #1;
    modelReset();
    checkOutput(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    rst_n = 1'b1;
    idleCycle();
    frame_q = {8'h55, 8'hD5, 8'h01, 8'h02};
    sendFrame(-1, 0);
    idleCycle();

`ifdef SGMII_RX_PCS_STATS_EN
    checkVal("stats rx_err_count", rx_err_count, 16'(m_err_beats));
    checkVal("stats rx_frame_count", rx_frame_count, 16'(m_frames));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
